pc_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the processor top. It owns the program counter and drives the 32-bit `address` into the instruction memory.
- Latches the returned instruction into an IF/ID pipeline register that feeds the control unit and register file.
- Resolves redirects (branch_eq, branch_ne, jump) signalled by the decode stage, with flush and stall handling.
- No branch delay slot: a taken redirect squashes the one wrongly fetched instruction.

---
 rtl/pc_fetch_unit.sv | 50 +++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, IF/ID register and branch/jump redirect for the fetch stage
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_index,
  input  logic [31:0] instr_in,
  output logic [31:0] address,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        redirect
);
  logic        br_taken;
  logic        jmp_taken;
  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] next_pc;
  always_comb begin
    br_taken   = if_valid & ((branch_eq & zero) | (branch_ne & ~zero));
    jmp_taken  = if_valid & jump;
    redirect   = ~stall & (br_taken | jmp_taken);
    pc4        = address + 32'd4;
    br_target  = if_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    jmp_target = {if_pc4[31:28], jump_index, 2'b00};
    next_pc    = jmp_taken ? jmp_target : br_taken ? br_target : pc4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      address  <= RESET_PC;
      if_instr <= NOP_INSTR;
      if_pc4   <= 32'd0;
      if_valid <= 1'b0;
    end else if (!stall) begin
      address  <= next_pc;
      if_instr <= redirect ? NOP_INSTR : instr_in;
      if_pc4   <= redirect ? 32'd0 : pc4;
      if_valid <= ~redirect;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a cycle-level reference model
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_eq = 1'b0;
  logic        branch_ne = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] instr_in, instr_w, instr_j;
  logic [31:0] address, if_instr, if_pc4;
  logic        if_valid, redirect;
  logic [31:0] a_w, i_w, p_w, a_j, i_j, p_j;
  logic        v_w, r_w, v_j, r_j;
  logic        hash = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_addr, m_instr, m_pc4;
  logic        m_valid;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .imm16(imm16), .jump_index(jump_index), .instr_in(instr_in),
    .address(address), .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid), .redirect(redirect)
  );
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .imm16(imm16), .jump_index(jump_index), .instr_in(instr_w),
    .address(a_w), .if_instr(i_w), .if_pc4(p_w), .if_valid(v_w), .redirect(r_w)
  );
  pc_fetch_unit #(.RESET_PC(32'h4000_000C)) dut_j (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .imm16(imm16), .jump_index(jump_index), .instr_in(instr_j),
    .address(a_j), .if_instr(i_j), .if_pc4(p_j), .if_valid(v_j), .redirect(r_j)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return hash ? (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F : a;
  endfunction

  assign instr_in = mem(address);
  assign instr_w  = a_w;
  assign instr_j  = a_j;

  function automatic logic model_redirect();
    return !stall && m_valid && (jump || (branch_eq && zero) || (branch_ne && !zero));
  endfunction

  task automatic tick();
    logic [31:0] n_addr, n_instr, n_pc4;
    logic        n_valid;
    n_addr = m_addr; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    if (rst) begin
      n_addr = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
    end else if (!stall) begin
      if (model_redirect()) begin
        if (jump) n_addr = (m_pc4 & 32'hF000_0000) | (32'(jump_index) << 2);
        else      n_addr = m_pc4 + 32'($signed(imm16)) * 32'd4;
        n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      end else begin
        n_addr = m_addr + 32'd4; n_instr = mem(m_addr); n_pc4 = m_addr + 32'd4; n_valid = 1'b1;
      end
    end
    @(posedge clk);
    m_addr = n_addr; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; branch_eq = 0; branch_ne = 0; zero = 0; jump = 0; imm16 = 0; jump_index = 0;
  endtask

  task automatic goto_pc10();
    clear_ctrl(); rst = 1; tick(); rst = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    stall = 1; jump = 1; rst = 1;
    tick(); tick();
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", address, 32'h0); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", if_instr, 32'h0); end
    checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp %h", if_pc4, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    clear_ctrl();
  endtask

  task automatic test_free_run();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (address !== 32'(4 * (i + 1))) begin errors++; $display("FAIL run_addr%0d got %h exp %h", i, address, 32'(4 * (i + 1))); end
      checks++; if (if_instr !== 32'(4 * i)) begin errors++; $display("FAIL run_instr%0d got %h exp %h", i, if_instr, 32'(4 * i)); end
      checks++; if (if_pc4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL run_pc4%0d got %h exp %h", i, if_pc4, 32'(4 * i + 4)); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL run_valid%0d got %b exp 1", i, if_valid); end
    end
  endtask

  task automatic test_beq(input logic [15:0] imm, input logic [31:0] tgt);
    goto_pc10();
    branch_eq = 1; zero = 1; imm16 = imm; #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got %b exp 1", redirect); end
    tick();
    checks++; if (address !== tgt) begin errors++; $display("FAIL beq_addr got %h exp %h", address, tgt); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL beq_bubble got %b exp 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL beq_nop got %h exp %h", if_instr, 32'h0); end
    clear_ctrl(); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL beq_bubble_redirect got %b exp 0", redirect); end
    tick();
    checks++; if (if_instr !== tgt) begin errors++; $display("FAIL beq_target_instr got %h exp %h", if_instr, tgt); end
    checks++; if (if_pc4 !== tgt + 32'd4) begin errors++; $display("FAIL beq_target_pc4 got %h exp %h", if_pc4, tgt + 32'd4); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL beq_target_valid got %b exp 1", if_valid); end
  endtask

  task automatic test_bne_not_taken();
    goto_pc10();
    branch_ne = 1; zero = 1; imm16 = 16'h0003; #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL bne_redirect got %b exp 0", redirect); end
    tick();
    checks++; if (address !== 32'h18) begin errors++; $display("FAIL bne_addr got %h exp %h", address, 32'h18); end
    checks++; if (if_instr !== 32'h14 || if_valid !== 1'b1) begin errors++; $display("FAIL bne_ifid got %h/%b exp %h/1", if_instr, if_valid, 32'h14); end
    clear_ctrl();
  endtask

  task automatic test_jump_beats_branch();
    clear_ctrl(); rst = 1; tick(); rst = 0; tick();
    checks++; if (p_j !== 32'h4000_0010 || v_j !== 1'b1) begin errors++; $display("FAIL jmp_setup got %h/%b exp %h/1", p_j, v_j, 32'h4000_0010); end
    jump = 1; jump_index = 26'h0000100; branch_eq = 1; zero = 1; imm16 = 16'h0003; #1;
    checks++; if (r_j !== 1'b1) begin errors++; $display("FAIL jmp_redirect got %b exp 1", r_j); end
    tick();
    checks++; if (a_j !== 32'h4000_0400) begin errors++; $display("FAIL jmp_addr got %h exp %h", a_j, 32'h4000_0400); end
    checks++; if (v_j !== 1'b0) begin errors++; $display("FAIL jmp_bubble got %b exp 0", v_j); end
    clear_ctrl();
  endtask

  task automatic test_stall_redirect();
    goto_pc10();
    jump = 1; jump_index = 26'h40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect%0d got %b exp 0", i, redirect); end
      tick();
      checks++; if (address !== 32'h14 || if_instr !== 32'h10 || if_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got %h/%h/%b exp %h/%h/1", i, address, if_instr, if_valid, 32'h14, 32'h10);
      end
    end
    stall = 0; #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL stall_release_redirect got %b exp 1", redirect); end
    tick();
    checks++; if (address !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %h/%b exp %h/0", address, if_valid, 32'h100); end
    clear_ctrl();
  endtask

  task automatic test_wrap_and_reset();
    clear_ctrl(); rst = 1; tick();
    checks++; if (a_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset got %h exp %h", a_w, 32'hFFFF_FFFC); end
    rst = 0; tick();
    checks++; if (a_w !== 32'h0 || p_w !== 32'h0 || v_w !== 1'b1 || i_w !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_next got %h/%h/%b/%h exp 0/0/1/fffffffc", a_w, p_w, v_w, i_w);
    end
    goto_pc10();
    branch_eq = 1; zero = 1; imm16 = 16'h0003; rst = 1;
    tick();
    checks++; if (address !== 32'h0 || if_valid !== 1'b0 || if_pc4 !== 32'h0) begin
      errors++; $display("FAIL midreset got %h/%b/%h exp 0/0/0", address, if_valid, if_pc4);
    end
    rst = 0; clear_ctrl();
  endtask

  task automatic test_random();
    hash = 1; rst = 1; clear_ctrl(); tick(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch_eq  = ($urandom_range(0, 4) == 0);
      branch_ne  = ($urandom_range(0, 4) == 0);
      jump       = ($urandom_range(0, 7) == 0);
      zero       = 1'($urandom);
      imm16      = 16'($urandom);
      jump_index = 26'($urandom);
      #1;
      checks++; if (redirect !== model_redirect()) begin errors++; $display("FAIL rnd_redirect%0d got %b exp %b", i, redirect, model_redirect()); end
      tick();
      checks++; if (address !== m_addr) begin errors++; $display("FAIL rnd_addr%0d got %h exp %h", i, address, m_addr); end
      checks++; if (if_instr !== m_instr) begin errors++; $display("FAIL rnd_instr%0d got %h exp %h", i, if_instr, m_instr); end
      checks++; if (if_pc4 !== m_pc4) begin errors++; $display("FAIL rnd_pc4%0d got %h exp %h", i, if_pc4, m_pc4); end
      checks++; if (if_valid !== m_valid) begin errors++; $display("FAIL rnd_valid%0d got %b exp %b", i, if_valid, m_valid); end
      checks++; if (address[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align%0d got %h exp 0", i, address[1:0]); end
    end
    rst = 0; clear_ctrl(); hash = 0;
  endtask

  initial begin
    m_addr = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    #1;
    test_reset();
    test_free_run();
    test_beq(16'h0003, 32'h20);
    test_beq(16'hFFFE, 32'h0C);
    test_bne_not_taken();
    test_jump_beats_branch();
    test_stall_redirect();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
